// File: rtl/spi_pkg.sv
// Shared SPI definitions: controller state encoding, default word width and bus mode.
// Also intended for a future peripheral-side model or block.
package spi_pkg;

    localparam int unsigned SPI_BYTE_W = 8;
    // CPOL=0, CPHA=0: SCK idles low, data sampled on the rising edge
    localparam logic [1:0]  SPI_MODE   = 2'd0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GAP   = 3'd4
    } spi_state_e;

endpackage

// File: rtl/spi_sclk_gen.sv
// Half-period counter for the SPI clock: ticks every HALF_DIV cycles while enabled
// and toggles SCK on ticks where toggling is permitted.
module spi_sclk_gen #(
    parameter int unsigned HALF_DIV = 3
) (
    input  logic m_clk,
    input  logic rst_n,
    input  logic en,
    input  logic sck_en,
    output logic tick,
    output logic rise_stb,
    output logic fall_stb,
    output logic sck
);

    localparam int unsigned CW = (HALF_DIV < 2) ? 1 : $clog2(HALF_DIV);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          sck_q, sck_d;

    always_ff @(posedge m_clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            sck_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sck_q <= sck_d;
        end
    end

    always_comb begin
        tick     = en && (cnt_q == CW'(HALF_DIV - 1));
        rise_stb = tick && sck_en && !sck_q;
        fall_stb = tick && sck_en && sck_q;
        cnt_d    = cnt_q;
        sck_d    = sck_q;
        // Counter rests at zero while disabled so every phase starts a full half-period
        if (!en || tick) cnt_d = '0;
        else             cnt_d = cnt_q + CW'(1);
        if (tick && sck_en) sck_d = !sck_q;
    end

    assign sck = sck_q;

endmodule

// File: rtl/spi_controller.sv
// SPI mode-0 master for single-word transfers: IDLE -> SETUP -> SHIFT -> HOLD -> GAP.
// One shift register carries the outgoing word out of its MSB and collects MISO into its LSB.
module spi_controller
    import spi_pkg::*;
#(
    parameter int unsigned BYTE_W   = SPI_BYTE_W,
    parameter int unsigned HALF_DIV = 3
) (
    input  logic              m_clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [BYTE_W-1:0] d_to_send,
    output logic [BYTE_W-1:0] d_received,
    output logic              busy,
    output logic              DRDY,
    output logic              sck_pad,
    output logic              csn_pad,
    output logic              mosi_pad,
    input  logic              miso_pad,
    output spi_state_e        dbg_state
);

    localparam int unsigned BCW = (BYTE_W < 2) ? 1 : $clog2(BYTE_W);

    spi_state_e        state_q, state_d;
    logic [BYTE_W-1:0] sreg_q, sreg_d;
    logic [BYTE_W-1:0] rx_q, rx_d;
    logic [BCW-1:0]    bit_cnt_q, bit_cnt_d;
    logic              mosi_q, mosi_d;
    logic              csn_q, csn_d;
    logic              busy_q, busy_d;
    logic              drdy_q, drdy_d;

    logic tick, rise_stb, fall_stb, last_fall;

    spi_sclk_gen #(.HALF_DIV(HALF_DIV)) u_sclk (
        .m_clk    (m_clk),
        .rst_n    (rst_n),
        .en       (state_q != ST_IDLE),
        .sck_en   ((state_q == ST_SETUP) || (state_q == ST_SHIFT)),
        .tick     (tick),
        .rise_stb (rise_stb),
        .fall_stb (fall_stb),
        .sck      (sck_pad)
    );

    assign last_fall = fall_stb && (bit_cnt_q == BCW'(BYTE_W - 1));

    always_ff @(posedge m_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            sreg_q    <= '0;
            rx_q      <= '0;
            bit_cnt_q <= '0;
            mosi_q    <= 1'b0;
            csn_q     <= 1'b1;
            busy_q    <= 1'b0;
            drdy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sreg_q    <= sreg_d;
            rx_q      <= rx_d;
            bit_cnt_q <= bit_cnt_d;
            mosi_q    <= mosi_d;
            csn_q     <= csn_d;
            busy_q    <= busy_d;
            drdy_q    <= drdy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start)     state_d = ST_SETUP;
            ST_SETUP: if (tick)      state_d = ST_SHIFT;
            ST_SHIFT: if (last_fall) state_d = ST_HOLD;
            ST_HOLD:  if (tick)      state_d = ST_GAP;
            ST_GAP:   if (tick)      state_d = ST_IDLE;
            default:                 state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        sreg_d    = sreg_q;
        rx_d      = rx_q;
        bit_cnt_d = bit_cnt_q;
        mosi_d    = mosi_q;
        csn_d     = csn_q;
        busy_d    = busy_q;
        drdy_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    sreg_d    = d_to_send;
                    mosi_d    = d_to_send[BYTE_W-1];
                    bit_cnt_d = '0;
                    csn_d     = 1'b0;
                    busy_d    = 1'b1;
                end
            end
            ST_SETUP, ST_SHIFT: begin
                if (rise_stb) sreg_d = {sreg_q[BYTE_W-2:0], miso_pad};
                // After k rises the MSB already holds the next outgoing bit
                if (fall_stb && !last_fall) begin
                    mosi_d    = sreg_q[BYTE_W-1];
                    bit_cnt_d = bit_cnt_q + BCW'(1);
                end
            end
            ST_HOLD: begin
                if (tick) begin
                    csn_d  = 1'b1;
                    mosi_d = 1'b0;
                    rx_d   = sreg_q;
                    drdy_d = 1'b1;
                end
            end
            ST_GAP: begin
                if (tick) busy_d = 1'b0;
            end
            default: ;
        endcase
    end

    assign d_received = rx_q;
    assign busy       = busy_q;
    assign DRDY       = drdy_q;
    assign csn_pad    = csn_q;
    assign mosi_pad   = mosi_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_spi_controller.sv
// Directed bench for spi_controller: one instance at HALF_DIV=2 (loopback or
// peripheral model on MISO) and one at HALF_DIV=1 in loopback with start held high.
module tb_spi_controller;
    import spi_pkg::*;

    // ---------------- clock / reset ----------------
    logic m_clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 m_clk = ~m_clk;

    // ---------------- DUT, HALF_DIV = 2 ----------------
    logic       start = 1'b0;
    logic [7:0] d_to_send = 8'h00;
    logic [7:0] d_received;
    logic       busy, drdy, sck_pad, csn_pad, mosi_pad, miso_pad;
    spi_state_e dbg_state;

    spi_controller #(.BYTE_W(8), .HALF_DIV(2)) u_dut (
        .m_clk      (m_clk),
        .rst_n      (rst_n),
        .start      (start),
        .d_to_send  (d_to_send),
        .d_received (d_received),
        .busy       (busy),
        .DRDY       (drdy),
        .sck_pad    (sck_pad),
        .csn_pad    (csn_pad),
        .mosi_pad   (mosi_pad),
        .miso_pad   (miso_pad),
        .dbg_state  (dbg_state)
    );

    // ---------------- DUT, HALF_DIV = 1, MISO looped back ----------------
    logic       start1 = 1'b0;
    logic [7:0] d1 = 8'h00;
    logic [7:0] rx1;
    logic       busy1, drdy1, sck1, csn1, mosi1;
    spi_state_e dbg_state1;

    spi_controller #(.BYTE_W(8), .HALF_DIV(1)) u_dut1 (
        .m_clk      (m_clk),
        .rst_n      (rst_n),
        .start      (start1),
        .d_to_send  (d1),
        .d_received (rx1),
        .busy       (busy1),
        .DRDY       (drdy1),
        .sck_pad    (sck1),
        .csn_pad    (csn1),
        .mosi_pad   (mosi1),
        .miso_pad   (mosi1),
        .dbg_state  (dbg_state1)
    );

    // ---------------- peripheral model: MSB first, next bit after each SCK rise ----------------
    logic       loopback = 1'b1;
    logic [7:0] periph_byte = 8'h00;
    int         rise_cnt = 0;
    logic       periph_bit;

    always @(posedge sck_pad or posedge csn_pad) begin
        if (csn_pad) rise_cnt <= 0;
        else         rise_cnt <= rise_cnt + 1;
    end

    always_comb begin
        periph_bit = 1'b0;
        if (rise_cnt < 8) periph_bit = periph_byte[3'(7 - rise_cnt)];
    end

    assign miso_pad = loopback ? mosi_pad : periph_bit;

    // ---------------- scoreboard ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Results of the last run_xfer; cycle t = values seen after the t-th edge from start
    int         r_drdy_cnt, r_drdy_cyc, r_busy_low, r_csn_low, r_rises, r_glitch;
    logic [7:0] r_rx, r_mosi_bits;
    logic       r_done;

    // Called on a negedge: start is seen by the next edge (cycle 0 of the transfer)
    task automatic run_xfer(input logic [7:0] data, input int restart_at);
        logic       prev_sck;
        logic [7:0] prev_rx;
        r_drdy_cnt = 0; r_drdy_cyc = -1; r_busy_low = -1; r_csn_low = 0;
        r_rises = 0; r_glitch = 0; r_rx = 8'hxx; r_mosi_bits = 8'h00; r_done = 1'b0;
        prev_sck = 1'b0;
        prev_rx  = d_received;
        d_to_send = data;
        start     = 1'b1;
        for (int t = 1; t <= 100; t++) begin
            @(negedge m_clk);
            if (drdy) begin
                r_drdy_cnt++;
                r_drdy_cyc = t;
                r_rx = d_received;
            end else if (d_received !== prev_rx) begin
                r_glitch++;
            end
            prev_rx = d_received;
            if (!csn_pad) r_csn_low++;
            if (sck_pad && !prev_sck) begin
                r_rises++;
                r_mosi_bits = {r_mosi_bits[6:0], mosi_pad};
            end
            prev_sck = sck_pad;
            if (t == 1) begin
                start     = 1'b0;
                d_to_send = ~data;
            end
            if (restart_at > 0 && t == restart_at)     start = 1'b1;
            if (restart_at > 0 && t == restart_at + 1) start = 1'b0;
            if (!busy) begin
                r_busy_low = t;
                r_done = 1'b1;
                break;
            end
        end
        check("xfer_done", {31'd0, r_done}, 32'd1);
    endtask

    int         h_drdy_cnt, h_cyc0, h_cyc1;
    logic [7:0] h_rx0, h_rx1;
    logic       h_csn [17:20];
    logic       h_busy [19:20];
    int         a_drdy;

    initial begin
        // ---------------- reset values ----------------
        repeat (3) @(negedge m_clk);
        check("rst_csn",   {31'd0, csn_pad},  32'd1);
        check("rst_sck",   {31'd0, sck_pad},  32'd0);
        check("rst_mosi",  {31'd0, mosi_pad}, 32'd0);
        check("rst_busy",  {31'd0, busy},     32'd0);
        check("rst_drdy",  {31'd0, drdy},     32'd0);
        check("rst_rx",    {24'd0, d_received}, 32'h00);
        check("rst_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
        check("rst_csn1",  {31'd0, csn1},     32'd1);
        check("rst_busy1", {31'd0, busy1},    32'd0);
        rst_n = 1'b1;
        @(negedge m_clk);

        // ---------------- loopback 0xA5, HALF_DIV=2 ----------------
        loopback = 1'b1;
        run_xfer(8'hA5, 0);
        check("a5_rx",       {24'd0, r_rx}, 32'hA5);
        check("a5_drdy_cnt", r_drdy_cnt, 32'd1);
        check("a5_drdy_cyc", r_drdy_cyc, 32'd35);
        check("a5_busy_low", r_busy_low, 32'd37);
        check("a5_rises",    r_rises,    32'd8);
        check("a5_csn_low",  r_csn_low,  32'd34);
        check("a5_glitch",   r_glitch,   32'd0);
        check("a5_hold_rx",  {24'd0, d_received}, 32'hA5);

        // ---------------- peripheral returns 0x3C, controller sends 0x01 ----------------
        loopback    = 1'b0;
        periph_byte = 8'h3C;
        run_xfer(8'h01, 0);
        check("p_mosi_bits", {24'd0, r_mosi_bits}, 32'h01);
        check("p_rx",        {24'd0, r_rx}, 32'h3C);
        check("p_csn_low",   r_csn_low,  32'd34);
        check("p_drdy_cnt",  r_drdy_cnt, 32'd1);
        check("p_glitch",    r_glitch,   32'd0);

        // ---------------- second start pulse mid-transfer is ignored ----------------
        loopback = 1'b1;
        run_xfer(8'hC3, 10);
        check("r_drdy_cnt", r_drdy_cnt, 32'd1);
        check("r_rises",    r_rises,    32'd8);
        check("r_rx",       {24'd0, r_rx}, 32'hC3);
        check("r_busy_low", r_busy_low, 32'd37);
        repeat (5) @(negedge m_clk);
        check("r_no_rerun", {31'd0, busy}, 32'd0);

        // ---------------- reset during bit 3 (cycle 12, SCK high) ----------------
        a_drdy    = 0;
        d_to_send = 8'h96;
        start     = 1'b1;
        for (int t = 1; t <= 12; t++) begin
            @(negedge m_clk);
            if (t == 1) start = 1'b0;
            if (drdy) a_drdy++;
        end
        check("ab_sck_before", {31'd0, sck_pad}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("ab_csn",   {31'd0, csn_pad},  32'd1);
        check("ab_sck",   {31'd0, sck_pad},  32'd0);
        check("ab_mosi",  {31'd0, mosi_pad}, 32'd0);
        check("ab_busy",  {31'd0, busy},     32'd0);
        check("ab_rx",    {24'd0, d_received}, 32'h00);
        check("ab_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
        repeat (2) @(negedge m_clk);
        if (drdy) a_drdy++;
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge m_clk);
            if (drdy) a_drdy++;
        end
        check("ab_no_drdy", a_drdy, 32'd0);
        run_xfer(8'h5A, 0);
        check("ab_clean_rx",   {24'd0, r_rx}, 32'h5A);
        check("ab_clean_drdy", r_drdy_cnt, 32'd1);
        check("ab_clean_cyc",  r_drdy_cyc, 32'd35);

        // ---------------- HALF_DIV=1, start held high, 0xFF then 0x00 ----------------
        // First DRDY at 1+17=18, IDLE at 19 where the held start is seen, busy again at 20,
        // second DRDY 17 cycles later at 37; CSN is high through GAP and that IDLE cycle.
        h_drdy_cnt = 0; h_cyc0 = -1; h_cyc1 = -1; h_rx0 = 8'hxx; h_rx1 = 8'hxx;
        d1     = 8'hFF;
        start1 = 1'b1;
        for (int t = 1; t <= 45; t++) begin
            @(negedge m_clk);
            if (drdy1) begin
                if (h_drdy_cnt == 0) begin h_cyc0 = t; h_rx0 = rx1; end
                else                 begin h_cyc1 = t; h_rx1 = rx1; end
                h_drdy_cnt++;
            end
            if (t >= 17 && t <= 20) h_csn[t] = csn1;
            if (t >= 19 && t <= 20) h_busy[t] = busy1;
            if (t == 1)  d1 = 8'h00;
            if (t == 20) start1 = 1'b0;
        end
        check("h_drdy_cnt", h_drdy_cnt, 32'd2);
        check("h_cyc0",     h_cyc0,     32'd18);
        check("h_cyc1",     h_cyc1,     32'd37);
        check("h_rx0",      {24'd0, h_rx0}, 32'hFF);
        check("h_rx1",      {24'd0, h_rx1}, 32'h00);
        check("h_csn17",    {31'd0, h_csn[17]}, 32'd0);
        check("h_csn18",    {31'd0, h_csn[18]}, 32'd1);
        check("h_csn19",    {31'd0, h_csn[19]}, 32'd1);
        check("h_csn20",    {31'd0, h_csn[20]}, 32'd0);
        check("h_busy19",   {31'd0, h_busy[19]}, 32'd0);
        check("h_busy20",   {31'd0, h_busy[20]}, 32'd1);
        check("h_idle_end", {31'd0, busy1}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
